ctrl_pipe: RTL and testbench
============================

Name: ctrl_pipe

Overview:
- Receiving end of the decoded control bundle: carries ID-stage control signals through the ID/EX, EX/MEM and MEM/WB pipeline registers of the 5-stage RV64 pipeline.
- Owns load-use hazard detection (stall plus bubble insertion), branch flush, EX-stage forwarding selects and a saturating bubble counter.
- Sits between the instruction decoder and the datapath stage registers.

Parameters:
- REG_W, 5, register-index width.
- CNT_W, 16, bubble-counter width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch  in  1 each  decoded ID-stage control bits.
- ALUOp  in  2  decoded ID-stage ALU operation class.
- id_rs1, id_rs2, id_rd  in  REG_W  register indices of the instruction in ID.
- branch_taken  in  1  branch resolved taken in MEM.
- stall  out  1  hold PC and IF/ID this cycle.
- ex_ALUSrc out 1; ex_ALUOp out 2; ex_rs1, ex_rs2, ex_rd out REG_W: ID/EX contents.
- mem_MemRead, mem_MemWrite, mem_Branch out 1; mem_RegWrite out 1; mem_rd out REG_W: EX/MEM contents.
- wb_RegWrite, wb_MemtoReg out 1; wb_rd out REG_W: MEM/WB contents.
- ForwardA, ForwardB  out  2  EX operand select: 00 register file, 10 EX/MEM result, 01 MEM/WB result.
- bubble_cnt  out  CNT_W  count of bubbles inserted.

Behaviour:
- Reset (asynchronous, immediate): every stage register, every output and bubble_cnt go to 0. Stage contents equal a NOP bubble.
- Stage advance: every non-reset edge advances ID→EX→MEM→WB. There are no enables on EX/MEM or MEM/WB. Each control bit therefore reaches its consuming stage exactly 1, 2 or 3 cycles after ID.
- Load-use stall:
  - stall = ex_MemRead && ex_rd!=0 && (ex_rd==id_rs1 || ex_rd==id_rs2).
  - Purely combinational, same cycle.
  - When stall=1, the next ID/EX load is all-zero control with rd/rs=0 (a bubble).
  - The ID instruction is held upstream and re-presented the next cycle. The second presentation sees ex_MemRead=0 and proceeds.
  - Each load-use bubble costs exactly 1 cycle.
- Flush:
  - When branch_taken=1, the next ID/EX and EX/MEM loads are all zero, squashing the 2 younger instructions.
  - MEM/WB loads normally, so the branch itself retires.
  - stall is forced to 0 while branch_taken=1.
  - Flush has priority over stall.
- Forwarding (combinational), ForwardA shown:
  - 10 if mem_RegWrite && mem_rd!=0 && mem_rd==ex_rs1.
  - Else 01 if wb_RegWrite && wb_rd!=0 && wb_rd==ex_rs1.
  - Else 00.
  - ForwardB is identical using ex_rs2. The EX/MEM match wins when both match.
- x0 rule: rd=0 never causes a stall or a forward, even if RegWrite=1.
- bubble_cnt:
  - +1 on each edge where stall=1 inserts a bubble.
  - Flush-zeroed slots are not counted.
  - Saturates at all-ones; no wrap.
- Reset asserted mid-stall or mid-flush: all state clears at once and stall drops at once. After release the pipeline restarts empty.
- Input control bits are sampled only at the edge. Glitches between edges have no effect.

Test Plan:
- Reset release, then drive R-type (RegWrite=1, ALUOp=10, rd=5) for 1 cycle → ex_ALUOp=10 one cycle later; mem_RegWrite=1 after two; wb_RegWrite=1, wb_rd=5 after three; stall=0 throughout.
- Load-use: ld rd=7 followed by add rs1=7 → stall=1 for exactly 1 cycle; the ID/EX after the ld holds all zeros; bubble_cnt=1; the add then shows ForwardA=01 in EX.
- Double forward: add rd=3, add rd=3, add rs1=3 rs2=3 → ForwardA=ForwardB=10 (EX/MEM priority). With rd=0 and the same sequence → both 00.
- Flush: branch_taken=1 while a ld-use stall condition is present → stall=0; next ex_* and mem_* controls are 0; wb_* equals the branch's controls; bubble_cnt unchanged.
- Saturation: force 2^CNT_W+3 load-use stalls (CNT_W=4 in the bench) → bubble_cnt holds 15.
- Async reset pulsed mid-cycle during a stall → all outputs 0 before the next clk edge; normal flow resumes after release.

Source files
------------

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded ID-stage control through the ID/EX, EX/MEM and
// MEM/WB registers of the 5-stage pipeline. It also detects load-use hazards
// (stalling and inserting a bubble), squashes on a taken branch, produces the
// EX-stage forwarding selects and keeps a saturating count of bubbles.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   ALUSrc..Branch, ALUOp decoded control of the instruction in ID
//   id_rs1/id_rs2/id_rd   register indices of the instruction in ID
//   branch_taken          branch in MEM resolved taken
//   stall                 hold PC and IF/ID this cycle
//   ex_*                  ID/EX contents
//   mem_*                 EX/MEM contents
//   wb_*                  MEM/WB contents
//   ForwardA/ForwardB     EX operand select (00 regfile, 10 EX/MEM, 01 MEM/WB)
//   bubble_cnt            number of load-use bubbles inserted (saturating)
module ctrl_pipe #(
    parameter int REG_W = 5,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ALUSrc,
    input  logic             MemtoReg,
    input  logic             RegWrite,
    input  logic             MemRead,
    input  logic             MemWrite,
    input  logic             Branch,
    input  logic [1:0]       ALUOp,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             branch_taken,
    output logic             stall,
    output logic             ex_ALUSrc,
    output logic [1:0]       ex_ALUOp,
    output logic [REG_W-1:0] ex_rs1,
    output logic [REG_W-1:0] ex_rs2,
    output logic [REG_W-1:0] ex_rd,
    output logic             mem_MemRead,
    output logic             mem_MemWrite,
    output logic             mem_Branch,
    output logic             mem_RegWrite,
    output logic [REG_W-1:0] mem_rd,
    output logic             wb_RegWrite,
    output logic             wb_MemtoReg,
    output logic [REG_W-1:0] wb_rd,
    output logic [1:0]       ForwardA,
    output logic [1:0]       ForwardB,
    output logic [CNT_W-1:0] bubble_cnt
);

    // ID/EX control that is not exported but must travel on to later stages
    logic ex_MemtoReg;
    logic ex_RegWrite;
    logic ex_MemRead;
    logic ex_MemWrite;
    logic ex_Branch;
    logic mem_MemtoReg;

    logic load_use;

    // A load in EX whose destination is a source of the instruction in ID.
    // x0 never creates a dependency.
    assign load_use = ex_MemRead && (ex_rd != '0) &&
                      ((ex_rd == id_rs1) || (ex_rd == id_rs2));

    // A taken branch squashes the instruction in ID anyway, so holding it
    // would only lose a fetch slot.
    assign stall = load_use && !branch_taken;

    // ID/EX: zeroed on flush or when a bubble is inserted
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_ALUSrc   <= 1'b0;
            ex_ALUOp    <= 2'b00;
            ex_MemtoReg <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
        end else if (branch_taken || stall) begin
            ex_ALUSrc   <= 1'b0;
            ex_ALUOp    <= 2'b00;
            ex_MemtoReg <= 1'b0;
            ex_RegWrite <= 1'b0;
            ex_MemRead  <= 1'b0;
            ex_MemWrite <= 1'b0;
            ex_Branch   <= 1'b0;
            ex_rs1      <= '0;
            ex_rs2      <= '0;
            ex_rd       <= '0;
        end else begin
            ex_ALUSrc   <= ALUSrc;
            ex_ALUOp    <= ALUOp;
            ex_MemtoReg <= MemtoReg;
            ex_RegWrite <= RegWrite;
            ex_MemRead  <= MemRead;
            ex_MemWrite <= MemWrite;
            ex_Branch   <= Branch;
            ex_rs1      <= id_rs1;
            ex_rs2      <= id_rs2;
            ex_rd       <= id_rd;
        end
    end

    // EX/MEM: zeroed on flush (squashes the instruction behind the branch)
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_MemtoReg <= 1'b0;
            mem_RegWrite <= 1'b0;
            mem_MemRead  <= 1'b0;
            mem_MemWrite <= 1'b0;
            mem_Branch   <= 1'b0;
            mem_rd       <= '0;
        end else if (branch_taken) begin
            mem_MemtoReg <= 1'b0;
            mem_RegWrite <= 1'b0;
            mem_MemRead  <= 1'b0;
            mem_MemWrite <= 1'b0;
            mem_Branch   <= 1'b0;
            mem_rd       <= '0;
        end else begin
            mem_MemtoReg <= ex_MemtoReg;
            mem_RegWrite <= ex_RegWrite;
            mem_MemRead  <= ex_MemRead;
            mem_MemWrite <= ex_MemWrite;
            mem_Branch   <= ex_Branch;
            mem_rd       <= ex_rd;
        end
    end

    // MEM/WB: always loads, so the branch itself retires
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_RegWrite <= 1'b0;
            wb_MemtoReg <= 1'b0;
            wb_rd       <= '0;
        end else begin
            wb_RegWrite <= mem_RegWrite;
            wb_MemtoReg <= mem_MemtoReg;
            wb_rd       <= mem_rd;
        end
    end

    // Bubble counter sticks at all-ones
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (stall && (bubble_cnt != '1)) begin
            bubble_cnt <= bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Forwarding: the younger producer (EX/MEM) wins over MEM/WB
    always_comb begin
        ForwardA = 2'b00;
        ForwardB = 2'b00;
        if (mem_RegWrite && (mem_rd != '0) && (mem_rd == ex_rs1)) begin
            ForwardA = 2'b10;
        end else if (wb_RegWrite && (wb_rd != '0) && (wb_rd == ex_rs1)) begin
            ForwardA = 2'b01;
        end
        if (mem_RegWrite && (mem_rd != '0) && (mem_rd == ex_rs2)) begin
            ForwardB = 2'b10;
        end else if (wb_RegWrite && (wb_rd != '0) && (wb_rd == ex_rs2)) begin
            ForwardB = 2'b01;
        end
    end

endmodule

// File: tb/tb_ctrl_pipe.sv
module tb_ctrl_pipe;

    localparam int REG_W = 5;
    localparam int CNT_W = 4;

    typedef struct packed {
        logic             alusrc;
        logic [1:0]       aluop;
        logic             memtoreg;
        logic             regwrite;
        logic             memread;
        logic             memwrite;
        logic             branch;
        logic [REG_W-1:0] rs1;
        logic [REG_W-1:0] rs2;
        logic [REG_W-1:0] rd;
    } instr_t;

    logic             clk;
    logic             reset;
    logic             ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch;
    logic [1:0]       ALUOp;
    logic [REG_W-1:0] id_rs1, id_rs2, id_rd;
    logic             branch_taken;
    logic             stall;
    logic             ex_ALUSrc;
    logic [1:0]       ex_ALUOp;
    logic [REG_W-1:0] ex_rs1, ex_rs2, ex_rd;
    logic             mem_MemRead, mem_MemWrite, mem_Branch, mem_RegWrite;
    logic [REG_W-1:0] mem_rd;
    logic             wb_RegWrite, wb_MemtoReg;
    logic [REG_W-1:0] wb_rd;
    logic [1:0]       ForwardA, ForwardB;
    logic [CNT_W-1:0] bubble_cnt;

    logic [42:0]      all_out;

    int checks   = 0;
    int failures = 0;

    instr_t hist[$];

    assign all_out = {stall, ex_ALUSrc, ex_ALUOp, ex_rs1, ex_rs2, ex_rd,
                      mem_MemRead, mem_MemWrite, mem_Branch, mem_RegWrite, mem_rd,
                      wb_RegWrite, wb_MemtoReg, wb_rd, ForwardA, ForwardB, bubble_cnt};

    ctrl_pipe #(.REG_W(REG_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .ALUSrc(ALUSrc), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
        .MemRead(MemRead), .MemWrite(MemWrite), .Branch(Branch), .ALUOp(ALUOp),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .branch_taken(branch_taken), .stall(stall),
        .ex_ALUSrc(ex_ALUSrc), .ex_ALUOp(ex_ALUOp),
        .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd),
        .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite),
        .mem_Branch(mem_Branch), .mem_RegWrite(mem_RegWrite), .mem_rd(mem_rd),
        .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg), .wb_rd(wb_rd),
        .ForwardA(ForwardA), .ForwardB(ForwardB), .bubble_cnt(bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input instr_t i);
        ALUSrc   = i.alusrc;
        ALUOp    = i.aluop;
        MemtoReg = i.memtoreg;
        RegWrite = i.regwrite;
        MemRead  = i.memread;
        MemWrite = i.memwrite;
        Branch   = i.branch;
        id_rs1   = i.rs1;
        id_rs2   = i.rs2;
        id_rd    = i.rd;
    endtask

    function automatic instr_t mk_alu(input logic [REG_W-1:0] rs1, rs2, rd);
        instr_t i;
        i          = '0;
        i.aluop    = 2'b10;
        i.regwrite = 1'b1;
        i.rs1      = rs1;
        i.rs2      = rs2;
        i.rd       = rd;
        return i;
    endfunction

    function automatic instr_t mk_ld(input logic [REG_W-1:0] rs1, rd);
        instr_t i;
        i          = '0;
        i.alusrc   = 1'b1;
        i.memtoreg = 1'b1;
        i.regwrite = 1'b1;
        i.memread  = 1'b1;
        i.rs1      = rs1;
        i.rd       = rd;
        return i;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        drive('0);
        branch_taken = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        drive('0);
        branch_taken = 1'b0;
        reset = 1'b1;
        #1;
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_initial: outputs=%h want 0", all_out);
        end
        @(negedge clk);
        reset = 1'b0;
        tick();
        drive(mk_ld(5'd1, 5'd7));
        tick();
        drive(mk_alu(5'd2, 5'd3, 5'd4));
        tick();
        @(negedge clk);
        reset = 1'b1;
        #1;
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_async_busy: outputs=%h want 0", all_out);
        end
        drive('0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL reset_release: outputs=%h want 0", all_out);
        end
    endtask

    task automatic test_rtype();
        tick();
        drive(mk_alu(5'd0, 5'd0, 5'd5));
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL rtype_stall0: stall=%b want 0", stall);
        end
        tick();
        drive('0);
        @(negedge clk);
        checks++;
        if ({ex_ALUOp, ex_rd, stall} !== {2'b10, 5'd5, 1'b0}) begin
            failures++;
            $display("FAIL rtype_ex: aluop=%b rd=%0d stall=%b want 10 5 0", ex_ALUOp, ex_rd, stall);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({mem_RegWrite, mem_rd, stall} !== {1'b1, 5'd5, 1'b0}) begin
            failures++;
            $display("FAIL rtype_mem: regwrite=%b rd=%0d stall=%b want 1 5 0", mem_RegWrite, mem_rd, stall);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({wb_RegWrite, wb_rd, stall} !== {1'b1, 5'd5, 1'b0}) begin
            failures++;
            $display("FAIL rtype_wb: regwrite=%b rd=%0d stall=%b want 1 5 0", wb_RegWrite, wb_rd, stall);
        end
    endtask

    // Random hazard-free traffic checked against a history scoreboard:
    // hist holds [WB, MEM, EX, ID] expectations for the current cycle.
    task automatic test_flow();
        instr_t cur, prv, e, m, w;
        logic [1:0] fa, fb;
        logic st;
        apply_reset();
        hist.delete();
        repeat (3) hist.push_back('0);
        for (int k = 0; k < 60; k++) begin
            tick();
            prv          = hist[hist.size()-1];
            cur          = '0;
            cur.alusrc   = 1'($urandom_range(0, 1));
            cur.aluop    = 2'($urandom_range(0, 3));
            cur.memtoreg = 1'($urandom_range(0, 1));
            cur.regwrite = 1'($urandom_range(0, 1));
            cur.memread  = 1'($urandom_range(0, 1));
            cur.memwrite = 1'($urandom_range(0, 1));
            cur.branch   = 1'($urandom_range(0, 1));
            cur.rs1      = REG_W'($urandom_range(0, 7));
            cur.rs2      = REG_W'($urandom_range(0, 7));
            cur.rd       = REG_W'($urandom_range(0, 7));
            if (prv.memread && prv.rd != '0) begin
                if (cur.rs1 == prv.rd) cur.rs1 = cur.rs1 ^ 5'd1;
                if (cur.rs2 == prv.rd) cur.rs2 = cur.rs2 ^ 5'd1;
            end
            drive(cur);
            hist.push_back(cur);
            @(negedge clk);
            w = hist[0];
            m = hist[1];
            e = hist[2];
            st = e.memread && (e.rd != '0) && ((e.rd == cur.rs1) || (e.rd == cur.rs2));
            fa = (m.regwrite && m.rd != '0 && m.rd == e.rs1) ? 2'b10 :
                 (w.regwrite && w.rd != '0 && w.rd == e.rs1) ? 2'b01 : 2'b00;
            fb = (m.regwrite && m.rd != '0 && m.rd == e.rs2) ? 2'b10 :
                 (w.regwrite && w.rd != '0 && w.rd == e.rs2) ? 2'b01 : 2'b00;
            checks++;
            if ({ex_ALUSrc, ex_ALUOp, ex_rs1, ex_rs2, ex_rd} !== {e.alusrc, e.aluop, e.rs1, e.rs2, e.rd}) begin
                failures++;
                $display("FAIL flow_ex[%0d]: got %b %b %0d %0d %0d want %b %b %0d %0d %0d", k,
                         ex_ALUSrc, ex_ALUOp, ex_rs1, ex_rs2, ex_rd, e.alusrc, e.aluop, e.rs1, e.rs2, e.rd);
            end
            checks++;
            if ({mem_MemRead, mem_MemWrite, mem_Branch, mem_RegWrite, mem_rd} !==
                {m.memread, m.memwrite, m.branch, m.regwrite, m.rd}) begin
                failures++;
                $display("FAIL flow_mem[%0d]: got %b%b%b%b %0d want %b%b%b%b %0d", k,
                         mem_MemRead, mem_MemWrite, mem_Branch, mem_RegWrite, mem_rd,
                         m.memread, m.memwrite, m.branch, m.regwrite, m.rd);
            end
            checks++;
            if ({wb_RegWrite, wb_MemtoReg, wb_rd} !== {w.regwrite, w.memtoreg, w.rd}) begin
                failures++;
                $display("FAIL flow_wb[%0d]: got %b %b %0d want %b %b %0d", k,
                         wb_RegWrite, wb_MemtoReg, wb_rd, w.regwrite, w.memtoreg, w.rd);
            end
            checks++;
            if ({ForwardA, ForwardB} !== {fa, fb}) begin
                failures++;
                $display("FAIL flow_fwd[%0d]: got A=%b B=%b want A=%b B=%b", k, ForwardA, ForwardB, fa, fb);
            end
            checks++;
            if ({stall, bubble_cnt} !== {st, 4'd0}) begin
                failures++;
                $display("FAIL flow_stall[%0d]: got stall=%b cnt=%0d want %b 0", k, stall, bubble_cnt, st);
            end
            void'(hist.pop_front());
        end
    endtask

    task automatic test_load_use();
        apply_reset();
        tick();
        drive(mk_ld(5'd2, 5'd7));
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL lu_before: stall=%b want 0", stall);
        end
        tick();
        drive(mk_alu(5'd7, 5'd8, 5'd9));
        @(negedge clk);
        checks++;
        if (stall !== 1'b1) begin
            failures++;
            $display("FAIL lu_stall: stall=%b want 1", stall);
        end
        tick();
        drive(mk_alu(5'd7, 5'd8, 5'd9));
        @(negedge clk);
        checks++;
        if ({ex_ALUSrc, ex_ALUOp, ex_rs1, ex_rs2, ex_rd, stall} !== '0) begin
            failures++;
            $display("FAIL lu_bubble: ex=%b %b %0d %0d %0d stall=%b want all 0",
                     ex_ALUSrc, ex_ALUOp, ex_rs1, ex_rs2, ex_rd, stall);
        end
        checks++;
        if ({bubble_cnt, mem_MemRead, mem_rd} !== {4'd1, 1'b1, 5'd7}) begin
            failures++;
            $display("FAIL lu_count: cnt=%0d memread=%b memrd=%0d want 1 1 7", bubble_cnt, mem_MemRead, mem_rd);
        end
        tick();
        drive('0);
        @(negedge clk);
        checks++;
        if ({ex_rs1, ForwardA, ForwardB} !== {5'd7, 2'b01, 2'b00}) begin
            failures++;
            $display("FAIL lu_forward: rs1=%0d A=%b B=%b want 7 01 00", ex_rs1, ForwardA, ForwardB);
        end
    endtask

    task automatic test_double_fwd();
        apply_reset();
        tick(); drive(mk_alu(5'd1, 5'd2, 5'd3));
        tick(); drive(mk_alu(5'd4, 5'd5, 5'd3));
        tick(); drive(mk_alu(5'd3, 5'd3, 5'd4));
        tick(); drive('0);
        @(negedge clk);
        checks++;
        if ({ForwardA, ForwardB} !== 4'b1010) begin
            failures++;
            $display("FAIL fwd_double: A=%b B=%b want 10 10", ForwardA, ForwardB);
        end
        tick(); drive(mk_alu(5'd1, 5'd2, 5'd0));
        tick(); drive(mk_alu(5'd4, 5'd5, 5'd0));
        tick(); drive(mk_alu(5'd0, 5'd0, 5'd4));
        tick(); drive('0);
        @(negedge clk);
        checks++;
        if ({ForwardA, ForwardB} !== 4'b0000) begin
            failures++;
            $display("FAIL fwd_x0: A=%b B=%b want 00 00", ForwardA, ForwardB);
        end
        tick(); drive(mk_alu(5'd1, 5'd2, 5'd6));
        tick(); drive('0);
        tick(); drive(mk_alu(5'd6, 5'd1, 5'd4));
        tick(); drive('0);
        @(negedge clk);
        checks++;
        if ({ForwardA, ForwardB} !== 4'b0100) begin
            failures++;
            $display("FAIL fwd_wb_only: A=%b B=%b want 01 00", ForwardA, ForwardB);
        end
    endtask

    task automatic test_flush();
        instr_t br;
        br          = '0;
        br.branch   = 1'b1;
        br.regwrite = 1'b1;
        br.aluop    = 2'b01;
        br.rs1      = 5'd2;
        br.rs2      = 5'd3;
        br.rd       = 5'd1;
        apply_reset();
        tick(); drive(br);
        tick(); drive(mk_ld(5'd4, 5'd7));
        tick(); drive(mk_alu(5'd7, 5'd7, 5'd9));
        branch_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_stall: stall=%b want 0", stall);
        end
        tick();
        branch_taken = 1'b0;
        drive('0);
        @(negedge clk);
        checks++;
        if ({ex_ALUSrc, ex_ALUOp, ex_rs1, ex_rs2, ex_rd} !== '0) begin
            failures++;
            $display("FAIL flush_ex: ex=%b %b %0d %0d %0d want 0", ex_ALUSrc, ex_ALUOp, ex_rs1, ex_rs2, ex_rd);
        end
        checks++;
        if ({mem_MemRead, mem_MemWrite, mem_Branch, mem_RegWrite, mem_rd} !== '0) begin
            failures++;
            $display("FAIL flush_mem: mem=%b%b%b%b %0d want 0", mem_MemRead, mem_MemWrite, mem_Branch, mem_RegWrite, mem_rd);
        end
        checks++;
        if ({wb_RegWrite, wb_MemtoReg, wb_rd} !== {1'b1, 1'b0, 5'd1}) begin
            failures++;
            $display("FAIL flush_wb: wb=%b %b %0d want 1 0 1", wb_RegWrite, wb_MemtoReg, wb_rd);
        end
        checks++;
        if (bubble_cnt !== 4'd0) begin
            failures++;
            $display("FAIL flush_count: cnt=%0d want 0", bubble_cnt);
        end
    endtask

    task automatic test_saturation();
        logic [CNT_W-1:0] exp_cnt;
        apply_reset();
        for (int n = 1; n <= 19; n++) begin
            tick(); drive(mk_ld(5'd1, 5'd7));
            tick(); drive(mk_alu(5'd3, 5'd7, 5'd9));
            @(negedge clk);
            checks++;
            if (stall !== 1'b1) begin
                failures++;
                $display("FAIL sat_stall[%0d]: stall=%b want 1", n, stall);
            end
            tick(); drive(mk_alu(5'd3, 5'd7, 5'd9));
            @(negedge clk);
            exp_cnt = (n < 15) ? CNT_W'(n) : 4'd15;
            checks++;
            if ({stall, bubble_cnt} !== {1'b0, exp_cnt}) begin
                failures++;
                $display("FAIL sat_count[%0d]: stall=%b cnt=%0d want 0 %0d", n, stall, bubble_cnt, exp_cnt);
            end
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        tick(); drive(mk_ld(5'd1, 5'd7));
        tick(); drive(mk_alu(5'd7, 5'd2, 5'd9));
        tick(); drive(mk_alu(5'd7, 5'd2, 5'd9));
        tick(); drive(mk_ld(5'd1, 5'd7));
        tick(); drive(mk_alu(5'd7, 5'd2, 5'd9));
        @(negedge clk);
        checks++;
        if ({stall, bubble_cnt} !== {1'b1, 4'd1}) begin
            failures++;
            $display("FAIL ares_pre: stall=%b cnt=%0d want 1 1", stall, bubble_cnt);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (all_out !== '0) begin
            failures++;
            $display("FAIL ares_clear: outputs=%h want 0", all_out);
        end
        drive('0);
        #1;
        reset = 1'b0;
        test_rtype();
    endtask

    initial begin
        reset = 1'b0;
        branch_taken = 1'b0;
        drive('0);
        test_reset();
        apply_reset();
        test_rtype();
        test_flow();
        test_load_use();
        test_double_fwd();
        test_flush();
        test_saturation();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
